// File: rtl/bidir_bus_controller_if.sv
// Requester-side handshake bundle for bidir_bus_controller.
// Ports (as seen from the controller, slave modport):
//   req, req_wr, req_wdata  : in  - per-requester level request, direction (1=write), write data
//   gnt                     : out - registered one-hot grant
//   done, rd_valid          : out - completion pulse, read-completion pulse
//   rd_data                 : out - last sampled read value
//   bus_oe                  : out - tri-state buffer drive enable
//   busy                    : out - controller not idle
interface bidir_bus_controller_if #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;
    logic                  bus_oe;
    logic                  busy;

    modport master (
        output req, req_wr, req_wdata,
        input  gnt, done, rd_data, rd_valid, bus_oe, busy
    );

    modport slave (
        input  req, req_wr, req_wdata,
        output gnt, done, rd_data, rd_valid, bus_oe, busy
    );
endinterface

// File: rtl/bidir_bus_controller.sv
// Round-robin sequencer for a shared tri-state bus. Each granted
// transaction either drives the bus with latched data (write) or samples
// it while an external agent drives it (read). A turnaround gap of
// TURN_CYCLES is inserted whenever the direction differs from the
// previous transaction; the bus phase lasts HOLD_CYCLES.
// Ports:
//   clk    : in    - rising-edge clock
//   rst_n  : in    - synchronous active-low reset
//   bif    : slave - request/grant/status bundle (see bidir_bus_controller_if)
//   bus    : inout - shared bus, driven only while bus_oe is high
module bidir_bus_controller #(
    parameter int WIDTH       = 3,
    parameter int NREQ        = 2,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bidir_bus_controller_if.slave     bif,
    inout  wire  [WIDTH-1:0]          bus
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [NREQ-1:0]   gnt_q;
    logic              dir_q;      // latched direction of current transaction
    logic [WIDTH-1:0]  wdata_q;
    logic [IW-1:0]     win_q;
    logic [IW-1:0]     rr_ptr;
    logic              last_dir;   // direction of previous completed transaction
    logic [WIDTH-1:0]  rd_data_q;

    logic              any_req;
    logic              found;
    logic [IW-1:0]     win;

    // Round-robin pick: first set request starting at rr_ptr, wrapping.
    always_comb begin
        any_req = |bif.req;
        found   = 1'b0;
        win     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bif.req[(int'(rr_ptr) + i) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req)
                      state_nxt = (bif.req_wr[win] != last_dir) ? TURN : XFER;
            TURN: if (cnt == TURN_LAST) state_nxt = XFER;
            XFER: if (cnt == HOLD_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant/latch at arbitration, phase counter, read capture,
    // and the per-transaction bookkeeping committed on leaving DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            gnt_q     <= '0;
            dir_q     <= 1'b0;
            wdata_q   <= '0;
            win_q     <= '0;
            rr_ptr    <= '0;
            last_dir  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt_q   <= NREQ'(1) << win;
                    dir_q   <= bif.req_wr[win];
                    wdata_q <= bif.req_wdata[int'(win)*WIDTH +: WIDTH];
                    win_q   <= win;
                    cnt     <= '0;
                end
                TURN: cnt <= (cnt == TURN_LAST) ? '0 : cnt + 1'b1;
                XFER: begin
                    cnt <= (cnt == HOLD_LAST) ? '0 : cnt + 1'b1;
                    // Sample on the edge that ends the bus phase so the
                    // external driver has had the full hold window.
                    if (cnt == HOLD_LAST && !dir_q)
                        rd_data_q <= bus;
                end
                DONE: begin
                    gnt_q    <= '0;
                    last_dir <= dir_q;
                    rr_ptr   <= IW'((int'(win_q) + 1) % NREQ);
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode straight from the state register, so reset
    // releases the bus on the very edge it is sampled.
    logic oe;
    always_comb begin
        oe           = (state == XFER) && dir_q;
        bif.gnt      = gnt_q;
        bif.done     = (state == DONE);
        bif.rd_valid = (state == DONE) && !dir_q;
        bif.rd_data  = rd_data_q;
        bif.bus_oe   = oe;
        bif.busy     = (state != IDLE);
    end

    assign bus = oe ? wdata_q : {WIDTH{1'bz}};

endmodule
